// File: rtl/csi2_packet_parser_if.sv
// csi2_packet_parser_if: aligned word input and byte-enabled payload output bus
interface csi2_packet_parser_if;
  logic [31:0] word_in;
  logic word_valid;
  logic [31:0] payload_data;
  logic [3:0] payload_be;
  logic payload_valid;
  logic payload_last;
  modport master (output word_in, word_valid, input payload_data, payload_be, payload_valid, payload_last);
  modport slave (input word_in, word_valid, output payload_data, payload_be, payload_valid, payload_last);
endinterface

// File: rtl/csi2_packet_parser.sv
// csi2_packet_parser: CSI-2 header decode with ECC check, sync pulses and payload framing
module csi2_packet_parser #(
  parameter logic [15:0] MAX_WC = 16'd4096
) (
  input  logic mipi_clk,
  input  logic reset,
  input  logic stop,
  csi2_packet_parser_if.slave bus,
  output logic header_valid,
  output logic [1:0] virtual_channel,
  output logic [5:0] data_type,
  output logic [15:0] word_count,
  output logic frame_start,
  output logic frame_end,
  output logic line_start,
  output logic line_end,
  output logic ecc_error,
  output logic wc_error,
  output logic busy
);
  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, DRAIN} state_t;
  state_t state;
  logic [15:0] rem;
  logic [5:0] ecc;
  logic [23:0] d;
  logic [5:0] dt;
  logic [15:0] wc;
  logic long_ok;
  always_comb begin
    d = bus.word_in[23:0];
    dt = d[5:0];
    wc = d[23:8];
    ecc[0] = ^(d & 24'hF12CB7);
    ecc[1] = ^(d & 24'hF2555B);
    ecc[2] = ^(d & 24'h749A6D);
    ecc[3] = ^(d & 24'hB8E38E);
    ecc[4] = ^(d & 24'hDF03F0);
    ecc[5] = ^(d & 24'hEFFC00);
    long_ok = dt >= 6'h10 && wc != 16'd0 && wc <= MAX_WC;
  end
  assign busy = state == PAYLOAD || state == DRAIN;
  always_ff @(posedge mipi_clk) begin
    if (!reset) begin
      state <= IDLE;
      rem <= '0;
      header_valid <= 1'b0;
      virtual_channel <= '0;
      data_type <= '0;
      word_count <= '0;
      frame_start <= 1'b0;
      frame_end <= 1'b0;
      line_start <= 1'b0;
      line_end <= 1'b0;
      ecc_error <= 1'b0;
      wc_error <= 1'b0;
      bus.payload_data <= '0;
      bus.payload_be <= '0;
      bus.payload_valid <= 1'b0;
      bus.payload_last <= 1'b0;
    end else begin
      header_valid <= 1'b0;
      frame_start <= 1'b0;
      frame_end <= 1'b0;
      line_start <= 1'b0;
      line_end <= 1'b0;
      ecc_error <= 1'b0;
      wc_error <= 1'b0;
      bus.payload_valid <= 1'b0;
      bus.payload_last <= 1'b0;
      if (stop) state <= IDLE;
      else begin
        case (state)
          IDLE: state <= HEADER;
          HEADER: if (bus.word_valid) begin
            if (ecc != bus.word_in[29:24] || bus.word_in[31:30] != 2'b00) begin
              ecc_error <= 1'b1;
              state <= DRAIN;
            end else begin
              header_valid <= 1'b1;
              virtual_channel <= d[7:6];
              data_type <= dt;
              word_count <= wc;
              frame_start <= dt == 6'h00;
              frame_end <= dt == 6'h01;
              line_start <= dt == 6'h02;
              line_end <= dt == 6'h03;
              wc_error <= dt >= 6'h10 && wc > MAX_WC;
              rem <= long_ok ? wc : rem;
              state <= long_ok ? PAYLOAD : DRAIN;
            end
          end
          PAYLOAD: if (bus.word_valid) begin
            bus.payload_valid <= 1'b1;
            bus.payload_data <= bus.word_in;
            bus.payload_be <= rem >= 16'd4 ? 4'hF : (4'd1 << rem[1:0]) - 4'd1;
            bus.payload_last <= rem <= 16'd4;
            rem <= rem >= 16'd4 ? rem - 16'd4 : 16'd0;
            state <= rem <= 16'd4 ? DRAIN : PAYLOAD;
          end
          default: state <= DRAIN;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_csi2_packet_parser.sv
// tb_csi2_packet_parser: directed checks of header decode, sync pulses, payload framing and aborts
module tb_csi2_packet_parser;
  logic clk = 1'b0;
  logic reset, stop;
  logic header_valid, frame_start, frame_end, line_start, line_end, ecc_error, wc_error, busy;
  logic [1:0] virtual_channel;
  logic [5:0] data_type;
  logic [15:0] word_count;
  logic [9:0] flags;
  int total = 0;
  int bad = 0;
  localparam logic [9:0] HV = 10'h200, FS = 10'h100, LS = 10'h040, EE = 10'h010, WE = 10'h008, PV = 10'h004, PL = 10'h002, BZ = 10'h001;
  csi2_packet_parser_if bus ();
  csi2_packet_parser #(.MAX_WC(16'd4096)) dut (
    .mipi_clk(clk), .reset(reset), .stop(stop), .bus(bus),
    .header_valid(header_valid), .virtual_channel(virtual_channel), .data_type(data_type),
    .word_count(word_count), .frame_start(frame_start), .frame_end(frame_end),
    .line_start(line_start), .line_end(line_end), .ecc_error(ecc_error), .wc_error(wc_error), .busy(busy)
  );
  always #5 clk = ~clk;
  assign flags = {header_valid, frame_start, frame_end, line_start, line_end, ecc_error, wc_error, bus.payload_valid, bus.payload_last, busy};
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic s, input logic v, input logic [31:0] w);
    @(negedge clk);
    stop = s;
    bus.word_valid = v;
    bus.word_in = w;
    @(posedge clk);
    #1;
  endtask
  task automatic burst();
    step(1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
  endtask
  initial begin
    reset = 1'b0;
    stop = 1'b1;
    bus.word_valid = 1'b0;
    bus.word_in = '0;
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    chk("reset_flags", 32'(flags), 32'h0);
    chk("reset_wc", 32'(word_count), 32'h0);
    chk("reset_data", bus.payload_data, 32'h0);
    reset = 1'b1;
    burst();
    step(1'b0, 1'b1, 32'h1A000100);
    chk("fs_flags", 32'(flags), 32'(HV | FS | BZ));
    chk("fs_dt", 32'(data_type), 32'h00);
    chk("fs_wc", 32'(word_count), 32'h1);
    chk("fs_vc", 32'(virtual_channel), 32'h0);
    step(1'b0, 1'b1, 32'h12345678);
    chk("fs_drain", 32'(flags), 32'(BZ));
    step(1'b1, 1'b0, 32'h0);
    chk("stop_idle", 32'(flags), 32'h0);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h2F00062A);
    chk("raw_hdr", 32'(flags), 32'(HV | BZ));
    chk("raw_dt", 32'(data_type), 32'h2A);
    chk("raw_wc", 32'(word_count), 32'h6);
    step(1'b0, 1'b1, 32'h44332211);
    chk("raw_p0_flags", 32'(flags), 32'(PV | BZ));
    chk("raw_p0_data", bus.payload_data, 32'h44332211);
    chk("raw_p0_be", 32'(bus.payload_be), 32'hF);
    step(1'b0, 1'b1, 32'hCCBB6655);
    chk("raw_p1_flags", 32'(flags), 32'(PV | PL | BZ));
    chk("raw_p1_data", bus.payload_data, 32'hCCBB6655);
    chk("raw_p1_be", 32'(bus.payload_be), 32'h3);
    step(1'b0, 1'b1, 32'hDEADBEEF);
    chk("raw_crc_drop", 32'(flags), 32'(BZ));
    burst();
    step(1'b0, 1'b1, 32'h2E00062A);
    chk("ecc_flags", 32'(flags), 32'(EE | BZ));
    chk("ecc_dt_held", 32'(data_type), 32'h2A);
    chk("ecc_wc_held", 32'(word_count), 32'h6);
    step(1'b0, 1'b1, 32'h44332211);
    chk("ecc_no_payload", 32'(flags), 32'(BZ));
    burst();
    step(1'b0, 1'b1, 32'h3600102A);
    chk("abort_hdr", 32'(flags), 32'(HV | BZ));
    chk("abort_wc", 32'(word_count), 32'h10);
    step(1'b0, 1'b1, 32'hA0A0A0A0);
    chk("abort_p0", 32'(flags), 32'(PV | BZ));
    step(1'b0, 1'b1, 32'hB1B1B1B1);
    chk("abort_p1", 32'(flags), 32'(PV | BZ));
    step(1'b1, 1'b1, 32'hC2C2C2C2);
    chk("abort_stop", 32'(flags), 32'h0);
    chk("abort_wc_held", 32'(word_count), 32'h10);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h1A000100);
    chk("abort_fs", 32'(flags), 32'(HV | FS | BZ));
    chk("abort_fs_wc", 32'(word_count), 32'h1);
    burst();
    step(1'b0, 1'b1, 32'h2F00062A);
    step(1'b0, 1'b1, 32'h44332211);
    chk("rst_pre", 32'(flags), 32'(PV | BZ));
    reset = 1'b0;
    step(1'b0, 1'b1, 32'hCCBB6655);
    chk("rst_flags", 32'(flags), 32'h0);
    chk("rst_data", bus.payload_data, 32'h0);
    chk("rst_wc", 32'(word_count), 32'h0);
    chk("rst_dt", 32'(data_type), 32'h0);
    reset = 1'b1;
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h2F00062A);
    chk("rst_raw_hdr", 32'(flags), 32'(HV | BZ));
    step(1'b0, 1'b1, 32'h44332211);
    chk("rst_raw_p0", 32'(flags), 32'(PV | BZ));
    step(1'b0, 1'b0, 32'h0);
    chk("rst_raw_gap", 32'(flags), 32'(BZ));
    step(1'b0, 1'b1, 32'hCCBB6655);
    chk("rst_raw_p1", 32'(flags), 32'(PV | PL | BZ));
    chk("rst_raw_be", 32'(bus.payload_be), 32'h3);
    chk("rst_raw_data", bus.payload_data, 32'hCCBB6655);
    burst();
    step(1'b0, 1'b1, 32'h1000002A);
    chk("wc0_flags", 32'(flags), 32'(HV | BZ));
    chk("wc0_wc", 32'(word_count), 32'h0);
    step(1'b0, 1'b1, 32'h11111111);
    chk("wc0_drain", 32'(flags), 32'(BZ));
    burst();
    step(1'b0, 1'b1, 32'h1510012A);
    chk("wcmax_flags", 32'(flags), 32'(HV | WE | BZ));
    chk("wcmax_wc", 32'(word_count), 32'h1001);
    step(1'b0, 1'b1, 32'h22222222);
    chk("wcmax_drain", 32'(flags), 32'(BZ));
    burst();
    step(1'b0, 1'b1, 32'h0B000002);
    chk("ls_flags", 32'(flags), 32'(HV | LS | BZ));
    chk("ls_dt", 32'(data_type), 32'h02);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/csi2_packet_parser.md
# csi2_packet_parser

Downstream of the byte aligner in the MIPI CSI-2 receive path. Takes the 32-bit words assembled from lane0/lane1 (one word per `word_valid` strobe) and decodes the CSI-2 packet header: DI, WC and ECC. Emits frame and line sync pulses for short packets and byte-enabled payload words for long packets. Its output feeds the pixel/data handler that writes line buffers; it runs entirely in the `mipi_clk` domain.

## Interface
Parameters:
- `MAX_WC`, 16'd4096: largest accepted long-packet word count in bytes; a larger WC is a `wc_error`.

Ports:
- `mipi_clk`  in  1: byte-rate receive clock; the only clock.
- `reset`  in  1: synchronous, active-low; 0 = reset on the next `mipi_clk` rising edge.
- `stop`  in  1: active-high HS-burst abort/end from the SoT FSM; synchronous flush to IDLE.
- `word_in`  in  32: aligned word; byte0 = bits[7:0] is the first on wire.
- `word_valid`  in  1: `word_in` is valid this cycle. There is no backpressure.
- `header_valid`  out  1: 1-cycle pulse when a header passes the ECC check.
- `virtual_channel`  out  2: DI[7:6], held from the last good header.
- `data_type`  out  6: DI[5:0], held.
- `word_count`  out  16: header bits[23:8], held.
- `frame_start`, `frame_end`, `line_start`, `line_end`  out  1 each: 1-cycle pulses for DT 0x00/0x01/0x02/0x03.
- `payload_data`  out  32: payload word, byte-ordered as `word_in`.
- `payload_be`  out  4: byte enables; bit i qualifies bits[8i+7:8i].
- `payload_valid`  out  1: qualifies `payload_data`/`payload_be`.
- `payload_last`  out  1: marks the final payload word of the packet.
- `ecc_error`  out  1: 1-cycle pulse on header ECC mismatch.
- `wc_error`  out  1: 1-cycle pulse on long packet with WC > `MAX_WC`.
- `busy`  out  1: high in HEADER_WAIT... no — high in PAYLOAD or DRAIN.

## Operation
- States: IDLE, HEADER, PAYLOAD, DRAIN.
- IDLE: entered on reset or `stop`=1. When `stop`=0, go to HEADER.
- HEADER: the first `word_valid` word is the header.
  - Compute ECC over bits[23:0] with the standard CSI-2 6-bit parity equations; ecc[7:6]=0.
  - Compare the result with bits[31:24].
  - Mismatch: pulse `ecc_error`, go to DRAIN; held fields keep their old values.
  - Match: latch VC/DT/WC and pulse `header_valid`.
  - DT 0x00–0x03: also pulse the matching sync output, then go to DRAIN.
  - DT 0x04–0x0F (other short packets): `header_valid` only, then DRAIN.
  - DT ≥ 0x10 with WC=0: `header_valid` only, then DRAIN.
  - DT ≥ 0x10 with WC > `MAX_WC`: `header_valid` and `wc_error`, then DRAIN.
  - Otherwise load the 16-bit remaining-bytes counter `rem`=WC and go to PAYLOAD.
- PAYLOAD: on each `word_valid`:
  - `payload_data`=`word_in`.
  - `payload_be`=4'hF if `rem`≥4, else (1<<`rem`)−1.
  - `payload_last`=(`rem`≤4).
  - `rem`−=min(4,`rem`).
  - On the last word, go to DRAIN.
- CRC handling: the two trailing CRC bytes are not checked. CRC bytes sharing the last payload word are masked by `payload_be`; CRC bytes in any following word are discarded by DRAIN.
- DRAIN: ignore all words until `stop`=1. One packet per HS burst.
- `stop`=1 in any state, including mid-payload: go to IDLE next cycle, clear all pulses and `payload_valid`, and emit no `payload_last`. Held VC/DT/WC are kept.
- Reset: all outputs 0, `rem`=0, state IDLE.

## Timing
- All outputs are registered. Latency is 1 cycle from a `word_valid` edge to the corresponding output.
- Pulses are exactly 1 cycle wide. `payload_valid` is high only in cycles following a PAYLOAD-state `word_valid`; gaps in `word_valid` pass through as gaps.
- HEADER→PAYLOAD takes 1 cycle, so the word directly after the header may be payload and must not be lost.
- Simultaneous events:
  - `stop` and `word_valid` in the same cycle: `stop` wins; the word is dropped.
  - `reset`=0 and `stop`: reset wins.
- `busy`=1 in PAYLOAD and DRAIN, 0 in IDLE and HEADER. Reset value 0.

## Test plan
- FS short packet, VC0, frame number 1: `stop`↓, word 0x1A000100 → `header_valid`=1, `frame_start`=1, DT=0, WC=1, no payload; further words are ignored until `stop`.
- RAW8 line: header 0x2F00062A, then 0x44332211, 0xCCBB6655 → payload words 0x44332211 be F, then 0xCCBB6655 be 3 with `payload_last`; the third word is ignored.
- ECC error: 0x2E00062A → `ecc_error` pulse, no `header_valid`, no payload; held DT/WC unchanged.
- `stop` asserted mid-payload (WC=16, after 2 words) → `payload_valid` low next cycle, no `payload_last`. A following burst with a good FS header parses normally.
- `reset`=0 during PAYLOAD → all outputs 0 next cycle, state IDLE; a subsequent RAW8 packet is parsed correctly.
- Long packet with WC=0 → `header_valid` only. Long packet with WC=`MAX_WC`+1 → `header_valid` and `wc_error`, no payload.
